adc_conv_sched: RTL and testbench

- Scheduler that shares the single calibrated ADC converter path (ADC mux plus ADC-to-float stage) between two requesters: port 0 is the SPGD loop and port 1 is the housekeeping/GPIO monitor.
- Per request: select channel A or B, pulse the converter register reset, wait a settle time after any mux change, run one ADC_EN/ADC_DONE conversion, then return the float result to the granted requester.
- Sits between SPGD_SYS/monitor logic and the ADC_MUX/ADC_fp pair in the top level.

---
 rtl/adc_conv_sched.sv | 195 +++++++++++++++++++
 tb/tb_adc_conv_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_conv_sched.sv
// adc_conv_sched
// Shares the single calibrated ADC conversion path (ADC_MUX + ADC_fp) between
// two requesters: port 0 = SPGD loop, port 1 = housekeeping/GPIO monitor.
// Each granted request selects its channel, pulses the converter register
// reset, settles the mux when the channel changed (or was never settled),
// runs one ADC_EN/ADC_DONE handshake and returns the float to the requester.
//
// Ports:
//   ADC_CLK, RST_N     clock (rising edge), async active-low reset
//   SYS_EN             enable; low aborts any in-flight operation
//   REQ[1:0]           per-requester request, held until its RSP_VALID
//   REQ_SEL[1:0]       per-requester channel (1 = ADC A, 0 = ADC B)
//   ADC_SEL            mux / calibration select
//   REG_RST            one-cycle converter register reset
//   ADC_EN, ADC_DONE   converter handshake
//   ADC_CAL_IN         calibrated float from the converter
//   RSP_DATA           captured result, valid with RSP_VALID
//   RSP_VALID[1:0]     one-hot one-cycle response pulse
//   BUSY               high whenever not IDLE
//   ERR_CLR            clears TIMEOUT_ERR (a same-cycle timeout wins)
//   TIMEOUT_ERR        sticky converter-timeout flag
//   CONV_CNT           completed conversions, wrapping
module adc_conv_sched #(
    parameter int FP_WIDTH       = 32,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 ADC_CLK,
    input  logic                 RST_N,
    input  logic                 SYS_EN,
    input  logic [1:0]           REQ,
    input  logic [1:0]           REQ_SEL,
    output logic                 ADC_SEL,
    output logic                 REG_RST,
    output logic                 ADC_EN,
    input  logic                 ADC_DONE,
    input  logic [FP_WIDTH-1:0]  ADC_CAL_IN,
    output logic [FP_WIDTH-1:0]  RSP_DATA,
    output logic [1:0]           RSP_VALID,
    output logic                 BUSY,
    input  logic                 ERR_CLR,
    output logic                 TIMEOUT_ERR,
    output logic [CNT_WIDTH-1:0] CONV_CNT
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_SETTLE, S_CONV, S_RESP} state_t;

    typedef struct packed {
        logic port;    // granted requester
        logic settle;  // mux needs settling before ADC_EN
    } grant_t;

    state_t                state_q, state_d;
    grant_t                gnt_q, gnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  sel_valid_q, sel_valid_d;
    logic [SW-1:0]         settle_cnt_q, settle_cnt_d;
    logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;

    logic                  adc_sel_d, reg_rst_d, adc_en_d, busy_d, tmo_err_d;
    logic [FP_WIDTH-1:0]   rsp_data_d;
    logic [1:0]            rsp_valid_d;
    logic [CNT_WIDTH-1:0]  conv_cnt_d;
    logic                  tmo_set;

    // Round-robin: with both requesting, the one that did not go last wins.
    logic req_port, req_sel;
    assign req_port = (REQ == 2'b11) ? ~last_grant_q : REQ[1];
    assign req_sel  = REQ_SEL[req_port];

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        sel_valid_d  = sel_valid_q;
        settle_cnt_d = settle_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        adc_sel_d    = ADC_SEL;
        reg_rst_d    = 1'b0;
        adc_en_d     = 1'b0;
        rsp_data_d   = RSP_DATA;
        rsp_valid_d  = 2'b00;
        conv_cnt_d   = CONV_CNT;
        tmo_set      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (SYS_EN && (REQ != 2'b00)) begin
                    gnt_d.port   = req_port;
                    gnt_d.settle = (req_sel != ADC_SEL) || !sel_valid_q;
                    // Mux is unsettled until a full SETTLE completes; clearing
                    // here keeps an aborted settle from being trusted later.
                    if (gnt_d.settle) sel_valid_d = 1'b0;
                    adc_sel_d    = req_sel;
                    reg_rst_d    = 1'b1;
                    state_d      = S_CLR;
                end
            end
            S_CLR: begin
                settle_cnt_d = '0;
                tmo_cnt_d    = '0;
                if (gnt_q.settle) begin
                    state_d = S_SETTLE;
                end else begin
                    state_d  = S_CONV;
                    adc_en_d = 1'b1;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d     = S_CONV;
                    adc_en_d    = 1'b1;
                    sel_valid_d = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_CONV: begin
                if (ADC_DONE) begin
                    rsp_data_d              = ADC_CAL_IN;
                    rsp_valid_d[gnt_q.port] = 1'b1;
                    conv_cnt_d              = CONV_CNT + 1'b1;
                    state_d                 = S_RESP;
                end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Requester keeps REQ up; it is retried on a later grant.
                    tmo_set      = 1'b1;
                    last_grant_d = gnt_q.port;
                    state_d      = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    adc_en_d  = 1'b1;
                end
            end
            S_RESP: begin
                last_grant_d = gnt_q.port;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // SYS_EN low cancels whatever the state machine was about to issue.
        if (!SYS_EN && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            reg_rst_d    = 1'b0;
            adc_en_d     = 1'b0;
            rsp_valid_d  = 2'b00;
            rsp_data_d   = RSP_DATA;
            conv_cnt_d   = CONV_CNT;
            tmo_set      = 1'b0;
            last_grant_d = (state_q == S_RESP) ? gnt_q.port : last_grant_q;
        end

        tmo_err_d = tmo_set | (TIMEOUT_ERR & ~ERR_CLR);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            last_grant_q <= 1'b1;
            sel_valid_q  <= 1'b0;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            ADC_SEL      <= 1'b1;
            REG_RST      <= 1'b0;
            ADC_EN       <= 1'b0;
            RSP_DATA     <= '0;
            RSP_VALID    <= 2'b00;
            BUSY         <= 1'b0;
            TIMEOUT_ERR  <= 1'b0;
            CONV_CNT     <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            sel_valid_q  <= sel_valid_d;
            settle_cnt_q <= settle_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            ADC_SEL      <= adc_sel_d;
            REG_RST      <= reg_rst_d;
            ADC_EN       <= adc_en_d;
            RSP_DATA     <= rsp_data_d;
            RSP_VALID    <= rsp_valid_d;
            BUSY         <= busy_d;
            TIMEOUT_ERR  <= tmo_err_d;
            CONV_CNT     <= conv_cnt_d;
        end
    end

endmodule

// File: tb/tb_adc_conv_sched.sv
// Bench for adc_conv_sched: expected responses are queued when a request is
// issued and popped when RSP_VALID fires. Outputs are sampled on the falling
// edge; inputs are changed right after sampling.
module tb_adc_conv_sched;
    localparam int FPW    = 32;
    localparam int SETTLE = 4;
    localparam int TMO    = 16;
    localparam int CW     = 16;

    logic           ADC_CLK = 1'b0;
    logic           RST_N, SYS_EN, ADC_DONE, ERR_CLR;
    logic [1:0]     REQ, REQ_SEL;
    logic           ADC_SEL, REG_RST, ADC_EN, BUSY, TIMEOUT_ERR;
    logic [FPW-1:0] ADC_CAL_IN, RSP_DATA;
    logic [1:0]     RSP_VALID;
    logic [CW-1:0]  CONV_CNT;

    adc_conv_sched #(.FP_WIDTH(FPW), .SETTLE_CYCLES(SETTLE),
                     .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)) dut (
        .ADC_CLK(ADC_CLK), .RST_N(RST_N), .SYS_EN(SYS_EN), .REQ(REQ),
        .REQ_SEL(REQ_SEL), .ADC_SEL(ADC_SEL), .REG_RST(REG_RST),
        .ADC_EN(ADC_EN), .ADC_DONE(ADC_DONE), .ADC_CAL_IN(ADC_CAL_IN),
        .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .BUSY(BUSY),
        .ERR_CLR(ERR_CLR), .TIMEOUT_ERR(TIMEOUT_ERR), .CONV_CNT(CONV_CNT));

    always #5 ADC_CLK = ~ADC_CLK;

    typedef struct {
        logic [1:0]     vld;
        logic [FPW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;

    task automatic apply_reset();
        RST_N = 1'b0; SYS_EN = 1'b1; REQ = 2'b00; REQ_SEL = 2'b00;
        ADC_DONE = 1'b0; ADC_CAL_IN = '0; ERR_CLR = 1'b0;
        repeat (2) @(negedge ADC_CLK);
        RST_N = 1'b1;
        sb.delete();
        exp_cnt = 0;
        @(negedge ADC_CLK);
    endtask

    // One granted conversion: starts counting from the first IDLE cycle with
    // REQ already presented. settle: 1 = expect settle, 0 = none, 2 = unchecked.
    task automatic conv_step(input int port, input logic sel, input logic [FPW-1:0] data,
                             input int delay, input int settle, input string tag);
        int   e;
        bit   done;
        exp_t x;
        sb.push_back('{vld: 2'(1 << port), data: data});
        for (int i = 0; i < 50 && BUSY; i++) @(negedge ADC_CLK);
        e = -1;
        done = 1'b0;
        for (int n = 1; n <= 200 && !done; n++) begin
            @(negedge ADC_CLK);
            if (n == 1) begin
                checks += 2;
                if (REG_RST !== 1'b1) begin errors++; $display("FAIL %s reg_rst: got %b want 1", tag, REG_RST); end
                if (ADC_SEL !== sel) begin errors++; $display("FAIL %s adc_sel: got %b want %b", tag, ADC_SEL, sel); end
            end
            if (ADC_EN === 1'b1 && e < 0) begin
                e = n;
                if (settle != 2) begin
                    checks++;
                    if (e != ((settle == 1) ? SETTLE + 2 : 2)) begin
                        errors++;
                        $display("FAIL %s en_cycle: got %0d want %0d", tag, e, (settle == 1) ? SETTLE + 2 : 2);
                    end
                end
            end
            if (RSP_VALID !== 2'b00) begin
                done = 1'b1;
                checks += 4;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s scoreboard: unexpected rsp_valid %b", tag, RSP_VALID);
                end else begin
                    x = sb.pop_front();
                    exp_cnt++;
                    if (RSP_VALID !== x.vld) begin errors++; $display("FAIL %s rsp_valid: got %b want %b", tag, RSP_VALID, x.vld); end
                    if (RSP_DATA !== x.data) begin errors++; $display("FAIL %s rsp_data: got %h want %h", tag, RSP_DATA, x.data); end
                    if (CONV_CNT !== CW'(exp_cnt)) begin errors++; $display("FAIL %s conv_cnt: got %0d want %0d", tag, CONV_CNT, exp_cnt); end
                    if (ADC_EN !== 1'b0) begin errors++; $display("FAIL %s adc_en_in_resp: got %b want 0", tag, ADC_EN); end
                end
            end
            ADC_DONE   = (e > 0 && n == e + delay);
            ADC_CAL_IN = ADC_DONE ? data : 32'hDEADBEEF;
        end
        ADC_DONE = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s response: got none want rsp_valid within 200 cycles", tag);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 8;
        if (ADC_SEL !== 1'b1)     begin errors++; $display("FAIL reset adc_sel: got %b want 1", ADC_SEL); end
        if (REG_RST !== 1'b0)     begin errors++; $display("FAIL reset reg_rst: got %b want 0", REG_RST); end
        if (ADC_EN !== 1'b0)      begin errors++; $display("FAIL reset adc_en: got %b want 0", ADC_EN); end
        if (RSP_DATA !== '0)      begin errors++; $display("FAIL reset rsp_data: got %h want 0", RSP_DATA); end
        if (RSP_VALID !== 2'b00)  begin errors++; $display("FAIL reset rsp_valid: got %b want 00", RSP_VALID); end
        if (BUSY !== 1'b0)        begin errors++; $display("FAIL reset busy: got %b want 0", BUSY); end
        if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL reset timeout_err: got %b want 0", TIMEOUT_ERR); end
        if (CONV_CNT !== '0)      begin errors++; $display("FAIL reset conv_cnt: got %0d want 0", CONV_CNT); end
    endtask

    task automatic test_first_conv();
        REQ_SEL = 2'b01; REQ = 2'b01;
        conv_step(0, 1'b1, 32'h3F800000, 3, 1, "first");
        REQ = 2'b00;
    endtask

    task automatic test_same_channel();
        @(negedge ADC_CLK);
        REQ = 2'b01;
        conv_step(0, 1'b1, 32'h40000000, 2, 0, "same_chan");
        REQ = 2'b00;
    endtask

    task automatic test_round_robin();
        apply_reset();
        REQ_SEL = 2'b01; REQ = 2'b11;
        for (int i = 0; i < 4; i++)
            conv_step(i % 2, (i % 2) == 0, 32'h41000000 + i, 1 + i, 1, "round_robin");
        REQ = 2'b00;
    endtask

    task automatic test_timeout();
        int en_cnt;
        bit hit, rsp_seen;
        en_cnt = 0; hit = 1'b0; rsp_seen = 1'b0;
        @(negedge ADC_CLK);
        REQ_SEL = 2'b00; REQ = 2'b10;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge ADC_CLK);
            if (ADC_EN === 1'b1) en_cnt++;
            if (RSP_VALID !== 2'b00) rsp_seen = 1'b1;
            if (TIMEOUT_ERR === 1'b1) hit = 1'b1;
        end
        checks += 4;
        if (!hit)            begin errors++; $display("FAIL timeout flag: got 0 want 1"); end
        if (en_cnt != TMO)   begin errors++; $display("FAIL timeout en_cycles: got %0d want %0d", en_cnt, TMO); end
        if (rsp_seen)        begin errors++; $display("FAIL timeout rsp_valid: got pulse want none"); end
        if (BUSY !== 1'b0)   begin errors++; $display("FAIL timeout busy: got %b want 0", BUSY); end
        // REQ still held: the requester is re-granted and now completes.
        conv_step(1, 1'b0, 32'h40400000, 2, 0, "timeout_retry");
        REQ = 2'b00;
        checks++;
        if (TIMEOUT_ERR !== 1'b1) begin errors++; $display("FAIL timeout sticky: got %b want 1", TIMEOUT_ERR); end
        @(negedge ADC_CLK); ERR_CLR = 1'b1;
        @(negedge ADC_CLK); ERR_CLR = 1'b0;
        checks++;
        if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", TIMEOUT_ERR); end
    endtask

    task automatic test_sysen_abort();
        bit en_seen, busy_seen, rsp_seen;
        en_seen = 1'b0; busy_seen = 1'b0; rsp_seen = 1'b0;
        @(negedge ADC_CLK);
        REQ_SEL = 2'b01; REQ = 2'b01;   // ADC_SEL is 0 here: channel change
        for (int n = 1; n <= 4; n++) begin
            @(negedge ADC_CLK);
            if (ADC_EN === 1'b1) en_seen = 1'b1;
            if (n == 4) SYS_EN = 1'b0;  // third SETTLE cycle
        end
        for (int n = 5; n <= 8; n++) begin
            @(negedge ADC_CLK);
            if (ADC_EN === 1'b1) en_seen = 1'b1;
            if (BUSY !== 1'b0) busy_seen = 1'b1;
            if (RSP_VALID !== 2'b00) rsp_seen = 1'b1;
        end
        checks += 4;
        if (en_seen)   begin errors++; $display("FAIL abort adc_en: got high want never"); end
        if (busy_seen) begin errors++; $display("FAIL abort busy: got high want idle"); end
        if (rsp_seen)  begin errors++; $display("FAIL abort rsp_valid: got pulse want none"); end
        if (CONV_CNT !== CW'(exp_cnt)) begin errors++; $display("FAIL abort conv_cnt: got %0d want %0d", CONV_CNT, exp_cnt); end
        SYS_EN = 1'b1;
        conv_step(0, 1'b1, 32'h40800000, 2, 2, "abort_restart");
        REQ = 2'b00;
    endtask

    task automatic test_reset_mid_conv();
        bit in_conv;
        in_conv = 1'b0;
        @(negedge ADC_CLK);
        REQ_SEL = 2'b00; REQ = 2'b10;
        for (int i = 0; i < 50 && !in_conv; i++) begin
            @(negedge ADC_CLK);
            if (ADC_EN === 1'b1) in_conv = 1'b1;
        end
        checks++;
        if (!in_conv) begin errors++; $display("FAIL rst_mid reach_conv: got no adc_en want adc_en"); end
        RST_N = 1'b0;
        #1;
        checks += 6;
        if (ADC_EN !== 1'b0)      begin errors++; $display("FAIL rst_mid adc_en: got %b want 0", ADC_EN); end
        if (BUSY !== 1'b0)        begin errors++; $display("FAIL rst_mid busy: got %b want 0", BUSY); end
        if (ADC_SEL !== 1'b1)     begin errors++; $display("FAIL rst_mid adc_sel: got %b want 1", ADC_SEL); end
        if (CONV_CNT !== '0)      begin errors++; $display("FAIL rst_mid conv_cnt: got %0d want 0", CONV_CNT); end
        if (RSP_DATA !== '0)      begin errors++; $display("FAIL rst_mid rsp_data: got %h want 0", RSP_DATA); end
        if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL rst_mid timeout_err: got %b want 0", TIMEOUT_ERR); end
        REQ = 2'b00;
        @(negedge ADC_CLK);
        RST_N = 1'b1;
        sb.delete();
        exp_cnt = 0;
        @(negedge ADC_CLK);
        REQ_SEL = 2'b01; REQ = 2'b01;   // same channel as reset ADC_SEL, must still settle
        conv_step(0, 1'b1, 32'h40A00000, 3, 1, "post_reset");
        REQ = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_conv();
        test_same_channel();
        test_round_robin();
        test_timeout();
        test_sysen_abort();
        test_reset_mid_conv();
        repeat (2) @(negedge ADC_CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
